// File: rtl/amc_column_seq.sv
// Runs one MixColumns pass over a 128-bit state through the byte-serial amc_ise unit,
// five operations per column, and reassembles the result bytes into state_out.
//
// state | meaning
// IDLE  | waiting for go
// ISSUE | start pulse to amc_ise, operands valid
// GAP   | one cycle for amc_ise to raise wait_req
// POLL  | wait for amc_ise; store result, advance op/col, or time out
// DONE  | one-cycle done pulse
module amc_column_seq #(
    parameter int NCOL    = 4,
    parameter int TIMEOUT = 255
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         go,
    input  logic [127:0] state_in,
    input  logic [7:0]   sr_cfg,
    output logic         busy,
    output logic         done,
    output logic         err,
    output logic [127:0] state_out,
    output logic [7:0]   sr_status,
    output logic         amc_start,
    output logic [7:0]   amc_a,
    output logic [7:0]   amc_b,
    output logic [7:0]   amc_sr,
    input  logic [7:0]   amc_sr_out,
    input  logic [7:0]   amc_result,
    input  logic         amc_wait_req
);

    localparam int CW = (NCOL > 1) ? $clog2(NCOL) : 1;
    localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_GAP,
        S_POLL,
        S_DONE
    } state_t;

    state_t         state_r, state_nx;
    logic [127:0]   state_q;
    logic [7:0]     sr_q;
    logic [CW-1:0]  col;
    logic [2:0]     op;
    logic [TW-1:0]  tmo_cnt;
    logic [6:0]     col_lsb;
    logic [6:0]     wr_lsb;
    logic [31:0]    col_word;
    logic           tmo_hit;
    logic           last_op;

    // Timer is a down-counter; a TIMEOUT of 0 loads 0, which never reaches terminal count.
    assign tmo_hit = amc_wait_req && (tmo_cnt == TW'(1));
    assign last_op = (op == 3'd4) && (col == CW'(NCOL - 1));

    always_comb begin
        col_lsb  = 7'((NCOL - 1 - int'(col)) * 32);
        wr_lsb   = col_lsb + {2'b00, op[1:0] - 2'd1, 3'b000};
        col_word = state_q[col_lsb +: 32];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= state_nx;
        end
    end

    always_comb begin
        state_nx = state_r;
        case (state_r)
            S_IDLE:  if (go) state_nx = S_ISSUE;
            S_ISSUE: state_nx = S_GAP;
            S_GAP:   state_nx = S_POLL;
            S_POLL: begin
                if (amc_wait_req) begin
                    if (tmo_hit) state_nx = S_DONE;
                end else if (last_op) begin
                    state_nx = S_DONE;
                end else begin
                    state_nx = S_ISSUE;
                end
            end
            S_DONE:  state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    always_comb begin
        busy      = (state_r == S_ISSUE) || (state_r == S_GAP) || (state_r == S_POLL);
        done      = (state_r == S_DONE);
        amc_start = (state_r == S_ISSUE);
        // op0 sends bytes 0/1; later ops keep presenting bytes 2/3
        amc_a     = (op == 3'd0) ? col_word[31:24] : col_word[15:8];
        amc_b     = (op == 3'd0) ? col_word[23:16] : col_word[7:0];
        amc_sr    = sr_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= '0;
            sr_q      <= '0;
            col       <= '0;
            op        <= '0;
            tmo_cnt   <= '0;
            err       <= 1'b0;
            state_out <= '0;
            sr_status <= '0;
        end else begin
            case (state_r)
                S_IDLE: begin
                    if (go) begin
                        state_q <= state_in;
                        sr_q    <= sr_cfg;
                        err     <= 1'b0;
                        col     <= '0;
                        op      <= '0;
                    end
                end
                S_ISSUE: tmo_cnt <= TW'(TIMEOUT);
                S_POLL: begin
                    if (amc_wait_req) begin
                        if (tmo_hit) begin
                            err <= 1'b1;
                        end else if (tmo_cnt != '0) begin
                            tmo_cnt <= tmo_cnt - TW'(1);
                        end
                    end else begin
                        if (op != 3'd0) state_out[wr_lsb +: 8] <= amc_result;
                        if (op != 3'd4) begin
                            op <= op + 3'd1;
                        end else begin
                            op <= '0;
                            if (col != CW'(NCOL - 1)) col <= col + CW'(1);
                            else sr_status <= amc_sr_out;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
